// File: rtl/mac_tx_sink_pkg.sv
// Shared types for the MAC transmit sink: widths, framing FSM states and the
// tagged FIFO entry carried from the framing checker to the serializer.
package mac_if_pkg;

  localparam int MOD_W          = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    IN_PKT,
    TRUNC
  } frame_state_e;

  typedef struct packed {
    logic [31:0]      data;
    logic             sop;
    logic             eop;
    logic [MOD_W-1:0] mod;
    logic             err;
  } fifo_entry_t;

endpackage

// File: rtl/mac_tx_sink_if.sv
// ff_tx_* word stream between a packet producer (master) and the MAC sink (slave).
interface mac_tx_sink_if;
  import mac_if_pkg::*;

  logic [31:0]      ff_tx_data;
  logic             ff_tx_sop;
  logic             ff_tx_eop;
  logic             ff_tx_err;
  logic [MOD_W-1:0] ff_tx_mod;
  logic             ff_tx_wren;
  logic             ff_tx_rdy;

  modport master (
    output ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_mod, ff_tx_wren,
    input  ff_tx_rdy
  );

  modport slave (
    input  ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_mod, ff_tx_wren,
    output ff_tx_rdy
  );
endinterface

// File: rtl/mac_tx_sink_fifo.sv
// Synchronous FIFO of tagged packet words; pointers carry a wrap bit so full
// and empty come straight from the pointer compare.
module mac_word_fifo
  import mac_if_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  fifo_entry_t wr_entry,
  input  logic        pop,
  output fifo_entry_t rd_entry,
  output logic        full,
  output logic        empty,
  output logic [AW:0] free
);

  fifo_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, used;
  logic        do_push, do_pop;

  assign used     = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign free     = (AW+1)'(DEPTH) - used;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = mem[rd_ptr_q[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/mac_tx_sink.sv
// MAC transmit sink: framing check, tagged word FIFO, MSB-first byte serializer.
// Define MAC_TX_SINK_STATS_EN to build the saturating packet/error counters.
module mac_tx_sink
  import mac_if_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_WORDS  = 512
) (
  input  logic          clk,
  input  logic          reset_n,
  mac_tx_sink_if.slave  tx,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_first,
  output logic          out_last,
  output logic          out_err,
  output logic          overflow,
  output logic          framing_err,
  output logic [15:0]   pkt_count,
  output logic [15:0]   err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_WORDS + 1);

  frame_state_e   state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           accepted, wr_en, ferr_set;
  fifo_entry_t    wr_entry, rd_entry, cur_q;
  logic           fifo_full, fifo_empty;
  logic [AW:0]    fifo_free;
  logic [AW+1:0]  free_after;
  logic           rdy_q, cur_valid_q, byte_done, word_done, load;
  logic [1:0]     byte_idx_q, last_idx, byte_sel;

  assign accepted = tx.ff_tx_wren && !fifo_full;

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    ferr_set = 1'b0;
    wr_entry = '{data: tx.ff_tx_data, sop: tx.ff_tx_sop, eop: tx.ff_tx_eop,
                 mod: tx.ff_tx_mod, err: tx.ff_tx_err && tx.ff_tx_eop};
    if (accepted) begin
      case (state_q)
        IDLE: begin
          if (!tx.ff_tx_sop) begin
            ferr_set = 1'b1;
          end else begin
            wr_en = 1'b1;
            cnt_d = CW'(1);
            if (!tx.ff_tx_eop) state_d = (MAX_WORDS > 2) ? IN_PKT : TRUNC;
          end
        end
        IN_PKT: begin
          wr_en = 1'b1;
          if (tx.ff_tx_sop) begin
            // A stray sop restarts framing; the previous packet never gets out_last.
            ferr_set = 1'b1;
            cnt_d    = CW'(1);
            if (tx.ff_tx_eop) state_d = IDLE;
          end else if (tx.ff_tx_eop) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(MAX_WORDS - 1)) state_d = TRUNC;
          end
        end
        TRUNC: begin
          if (tx.ff_tx_eop) begin
            wr_en        = 1'b1;
            wr_entry.err = 1'b1;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign free_after = (AW+2)'(fifo_free) - (AW+2)'(wr_en) + (AW+2)'(load);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      overflow    <= 1'b0;
      framing_err <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (free_after >= (AW+2)'(2));
      if (tx.ff_tx_wren && fifo_full) overflow    <= 1'b1;
      if (ferr_set)                   framing_err <= 1'b1;
    end
  end

  assign tx.ff_tx_rdy = rdy_q;

  mac_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (wr_en),
    .wr_entry (wr_entry),
    .pop      (load),
    .rd_entry (rd_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .free     (fifo_free)
  );

  // The next entry is loaded on the last byte's handshake, so words stream with no bubble.
  assign last_idx  = cur_q.eop ? 2'(BYTES_PER_WORD - 1) - cur_q.mod : 2'(BYTES_PER_WORD - 1);
  assign byte_done = cur_valid_q && out_ready;
  assign word_done = byte_done && (byte_idx_q == last_idx);
  assign load      = !fifo_empty && (!cur_valid_q || word_done);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q       <= '0;
      cur_valid_q <= 1'b0;
      byte_idx_q  <= '0;
    end else if (load) begin
      cur_q       <= rd_entry;
      cur_valid_q <= 1'b1;
      byte_idx_q  <= '0;
    end else if (word_done) begin
      cur_valid_q <= 1'b0;
      byte_idx_q  <= '0;
    end else if (byte_done) begin
      byte_idx_q  <= byte_idx_q + 2'd1;
    end
  end

  assign byte_sel  = 2'(BYTES_PER_WORD - 1) - byte_idx_q;
  assign out_data  = cur_q.data[{byte_sel, 3'b000} +: 8];
  assign out_valid = cur_valid_q;
  assign out_first = cur_valid_q && cur_q.sop && (byte_idx_q == 2'd0);
  assign out_last  = cur_valid_q && cur_q.eop && (byte_idx_q == last_idx);
  assign out_err   = out_last && cur_q.err;

`ifdef MAC_TX_SINK_STATS_EN
  logic last_fire;
  assign last_fire = out_last && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (last_fire) begin
      if (pkt_count != 16'hFFFF)            pkt_count <= pkt_count + 16'd1;
      if (out_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_mac_tx_sink.sv
// Directed bench for mac_tx_sink: a default instance plus a MAX_WORDS=8 instance
// for truncation, both fed the same word stream.
module tb_mac_tx_sink;
  import mac_if_pkg::*;

`ifdef MAC_TX_SINK_STATS_EN
  localparam logic [15:0] STATS = 16'd1;
`else
  localparam logic [15:0] STATS = 16'd0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
    logic       e;
  } byte_t;

  logic clk = 1'b0;
  logic reset_n;
  logic out_ready;

  mac_tx_sink_if tx ();
  mac_tx_sink_if tx8 ();

  assign tx8.ff_tx_data = tx.ff_tx_data;
  assign tx8.ff_tx_sop  = tx.ff_tx_sop;
  assign tx8.ff_tx_eop  = tx.ff_tx_eop;
  assign tx8.ff_tx_err  = tx.ff_tx_err;
  assign tx8.ff_tx_mod  = tx.ff_tx_mod;
  assign tx8.ff_tx_wren = tx.ff_tx_wren;

  logic [7:0]  m_data, t_data;
  logic        m_valid, m_first, m_last, m_err, m_ovf, m_ferr;
  logic        t_valid, t_first, t_last, t_err, t_ovf, t_ferr;
  logic [15:0] m_pkt, m_errc, t_pkt, t_errc;

  mac_tx_sink dut (
    .clk(clk), .reset_n(reset_n), .tx(tx),
    .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .out_first(m_first), .out_last(m_last), .out_err(m_err),
    .overflow(m_ovf), .framing_err(m_ferr), .pkt_count(m_pkt), .err_count(m_errc)
  );

  mac_tx_sink #(.FIFO_DEPTH(16), .MAX_WORDS(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .tx(tx8),
    .out_data(t_data), .out_valid(t_valid), .out_ready(out_ready),
    .out_first(t_first), .out_last(t_last), .out_err(t_err),
    .overflow(t_ovf), .framing_err(t_ferr), .pkt_count(t_pkt), .err_count(t_errc)
  );

  always #10 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  byte_t q_m[$];
  byte_t q_t[$];
  int    cyc_m[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid && out_ready) begin
      q_m.push_back('{m_data, m_first, m_last, m_err});
      cyc_m.push_back(cyc);
    end
    if (t_valid && out_ready) q_t.push_back('{t_data, t_first, t_last, t_err});
  end

  function automatic logic [31:0] rep(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b, b, b, b};
  endfunction

  task automatic set_idle();
    tx.ff_tx_wren = 1'b0;
    tx.ff_tx_sop  = 1'b0;
    tx.ff_tx_eop  = 1'b0;
    tx.ff_tx_err  = 1'b0;
    tx.ff_tx_mod  = '0;
    tx.ff_tx_data = '0;
  endtask

  task automatic drive(input logic [31:0] d, input logic sop, input logic eop,
                       input logic [1:0] mod, input logic err);
    tx.ff_tx_data = d;
    tx.ff_tx_sop  = sop;
    tx.ff_tx_eop  = eop;
    tx.ff_tx_mod  = mod;
    tx.ff_tx_err  = err;
    tx.ff_tx_wren = 1'b1;
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic send_word(input logic [31:0] d, input logic sop, input logic eop,
                           input logic [1:0] mod, input logic err);
    int waited = 0;
    while (!tx.ff_tx_rdy && waited < 500) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!tx.ff_tx_rdy) begin
      checks++;
      errors++;
      $display("FAIL send_rdy_timeout: rdy=%0b after %0d cycles, expected 1", tx.ff_tx_rdy, waited);
    end else begin
      drive(d, sop, eop, mod, err);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    out_ready = 1'b1;
    set_idle();
    repeat (3) @(posedge clk);
    q_m.delete();
    q_t.delete();
    cyc_m.delete();
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b1;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_valid, m_first, m_last, m_err, m_ovf, m_ferr, tx.ff_tx_rdy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: valid/first/last/err/ovf/ferr/rdy=%b expected 0000000",
               {m_valid, m_first, m_last, m_err, m_ovf, m_ferr, tx.ff_tx_rdy});
    end
    checks++;
    if ({m_data, m_pkt, m_errc} !== 40'd0) begin
      errors++;
      $display("FAIL reset_data_counts: data=%0h pkt=%0d err=%0d expected 0", m_data, m_pkt, m_errc);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tx.ff_tx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_release: rdy=%0b expected 1", tx.ff_tx_rdy);
    end
  endtask

  task automatic test_full_packet();
    logic [7:0] b;
    byte_t      exp;
    int         bad = 0;
    int         span;
    do_reset();
    for (int i = 0; i < 52; i++) begin
      b = 8'(4 * i);
      send_word({b, b + 8'd1, b + 8'd2, b + 8'd3}, i == 0, i == 51, 2'd0, 1'b0);
    end
    drain(120);
    checks++;
    if (q_m.size() !== 208) begin
      errors++;
      $display("FAIL full_count: got %0d bytes expected 208", q_m.size());
    end
    for (int j = 0; j < q_m.size(); j++) begin
      exp = '{8'(j), j == 0, j == 207, 1'b0};
      if (q_m[j] !== exp) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL full_bytes: %0d bytes wrong expected 0", bad);
    end
    span = (cyc_m.size() == 208) ? cyc_m[207] - cyc_m[0] : -1;
    checks++;
    if (span !== 207) begin
      errors++;
      $display("FAIL full_no_bubble: span=%0d cycles expected 207", span);
    end
    checks++;
    if (m_pkt !== STATS) begin
      errors++;
      $display("FAIL full_pkt_count: got %0d expected %0d", m_pkt, STATS);
    end
  endtask

  task automatic test_short_packet();
    do_reset();
    send_word(32'hAABBCCDD, 1'b1, 1'b1, 2'd3, 1'b0);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_latency_early: valid=%0b expected 0", m_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({m_valid, m_data, m_first, m_last, m_err} !== {1'b1, 8'hAA, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL short_byte: valid=%0b data=%0h first=%0b last=%0b err=%0b expected 1 aa 1 1 0",
               m_valid, m_data, m_first, m_last, m_err);
    end
    drain(10);
    checks++;
    if (q_m.size() !== 1) begin
      errors++;
      $display("FAIL short_count: got %0d bytes expected 1", q_m.size());
    end
  endtask

  task automatic test_backpressure();
    byte_t exp;
    int    bad = 0;
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(rep(k), k == 0, 1'b0, 2'd0, 1'b0);
      if (k == 14) begin
        checks++;
        if (tx.ff_tx_rdy !== 1'b1) begin
          errors++;
          $display("FAIL bp_rdy_high: rdy=%0b after word 14 expected 1", tx.ff_tx_rdy);
        end
      end
      if (k == 15) begin
        checks++;
        if (tx.ff_tx_rdy !== 1'b0) begin
          errors++;
          $display("FAIL bp_rdy_low: rdy=%0b after word 15 expected 0", tx.ff_tx_rdy);
        end
      end
      if (k == 16) begin
        checks++;
        if (m_ovf !== 1'b0) begin
          errors++;
          $display("FAIL bp_no_overflow: overflow=%0b after word 16 expected 0", m_ovf);
        end
      end
      if (k == 17) begin
        checks++;
        if (m_ovf !== 1'b1) begin
          errors++;
          $display("FAIL bp_overflow: overflow=%0b after word 17 expected 1", m_ovf);
        end
      end
    end
    out_ready = 1'b1;
    drain(100);
    checks++;
    if (q_m.size() !== 68) begin
      errors++;
      $display("FAIL bp_count: got %0d bytes expected 68", q_m.size());
    end
    for (int j = 0; j < q_m.size(); j++) begin
      exp = '{8'(j / 4), j == 0, 1'b0, 1'b0};
      if (q_m[j] !== exp) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_bytes: %0d bytes wrong expected 0", bad);
    end
    checks++;
    if ({m_ovf, m_ferr} !== 2'b10) begin
      errors++;
      $display("FAIL bp_sticky: overflow/framing_err=%b expected 10", {m_ovf, m_ferr});
    end
  endtask

  task automatic test_framing_err();
    logic [15:0] f_vec, l_vec;
    int          bad = 0;
    do_reset();
    send_word(rep(1), 1'b0, 1'b0, 2'd0, 1'b0);
    drain(10);
    checks++;
    if ({q_m.size() == 0, m_ferr} !== 2'b11) begin
      errors++;
      $display("FAIL ferr_nosop: bytes=%0d framing_err=%0b expected 0 bytes and 1", q_m.size(), m_ferr);
    end
    do_reset();
    send_word(rep(8'h20), 1'b1, 1'b0, 2'd0, 1'b0);
    send_word(rep(8'h21), 1'b0, 1'b0, 2'd0, 1'b0);
    send_word(rep(8'h22), 1'b1, 1'b0, 2'd0, 1'b0);
    send_word(rep(8'h23), 1'b0, 1'b1, 2'd0, 1'b0);
    drain(30);
    f_vec = '0;
    l_vec = '0;
    for (int j = 0; j < q_m.size() && j < 16; j++) begin
      f_vec[j] = q_m[j].f;
      l_vec[j] = q_m[j].l;
      if (q_m[j].d !== 8'(8'h20 + j / 4)) bad++;
    end
    checks++;
    if ({q_m.size() == 16, bad == 0} !== 2'b11) begin
      errors++;
      $display("FAIL ferr_resync_data: bytes=%0d bad=%0d expected 16 bytes, 0 bad", q_m.size(), bad);
    end
    checks++;
    if ({f_vec, l_vec} !== {16'h0101, 16'h8000}) begin
      errors++;
      $display("FAIL ferr_resync_markers: first=%h last=%h expected 0101 8000", f_vec, l_vec);
    end
    checks++;
    if (m_ferr !== 1'b1) begin
      errors++;
      $display("FAIL ferr_midsop: framing_err=%0b expected 1", m_ferr);
    end
  endtask

  task automatic test_truncation();
    byte_t exp;
    int    bad = 0;
    do_reset();
    for (int k = 0; k < 12; k++) send_word(rep(k), k == 0, k == 11, 2'd0, 1'b0);
    drain(120);
    checks++;
    if (q_t.size() !== 32) begin
      errors++;
      $display("FAIL trunc_count: got %0d bytes expected 32", q_t.size());
    end
    for (int j = 0; j < q_t.size(); j++) begin
      exp = '{(j < 28) ? 8'(j / 4) : 8'd11, j == 0, j == 31, j == 31};
      if (q_t[j] !== exp) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL trunc_bytes: %0d bytes wrong expected 0", bad);
    end
    checks++;
    if ({t_pkt, t_errc} !== {STATS, STATS}) begin
      errors++;
      $display("FAIL trunc_counts: pkt=%0d err=%0d expected %0d %0d", t_pkt, t_errc, STATS, STATS);
    end
    checks++;
    if ({q_m.size() == 48, q_m.size() == 48 && q_m[47].l && !q_m[47].e} !== 2'b11) begin
      errors++;
      $display("FAIL trunc_untruncated: main bytes=%0d expected 48 ending last without err", q_m.size());
    end
  endtask

  task automatic test_reset_mid();
    byte_t exp;
    int    bad = 0;
    do_reset();
    out_ready = 1'b0;
    send_word(rep(8'h40), 1'b1, 1'b0, 2'd0, 1'b0);
    send_word(rep(8'h41), 1'b0, 1'b0, 2'd0, 1'b0);
    send_word(rep(8'h42), 1'b0, 1'b0, 2'd0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_word(rep(8'h50), 1'b1, 1'b0, 2'd0, 1'b0);
    send_word(rep(8'h51), 1'b0, 1'b1, 2'd0, 1'b0);
    drain(20);
    checks++;
    if (q_m.size() !== 8) begin
      errors++;
      $display("FAIL rstmid_count: got %0d bytes expected 8", q_m.size());
    end
    for (int j = 0; j < q_m.size(); j++) begin
      exp = '{8'(8'h50 + j / 4), j == 0, j == 7, 1'b0};
      if (q_m[j] !== exp) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rstmid_bytes: %0d bytes wrong expected 0", bad);
    end
    checks++;
    if ({m_ovf, m_ferr} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_flags: overflow/framing_err=%b expected 00", {m_ovf, m_ferr});
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_packet();
    test_short_packet();
    test_backpressure();
    test_framing_err();
    test_truncation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tx_sink.md
Name: mac_tx_sink

Overview:
- Synthesizable responder for the MAC transmit FIFO interface, i.e. the receiving end of the ff_tx_* word stream that packet producers drive.
- Accepts 32-bit words framed by sop/eop/mod/err under rdy backpressure.
- Checks framing and buffers words in a tagged FIFO, then serializes them to a byte stream, MSB byte first, with first/last/err markers.
- Used as the MAC model in simulation and as the on-chip loopback sink for the SDR packet path.

Parameters:
- FIFO_DEPTH, 16: FIFO depth in 32-bit words; must be a power of 2, at least 4.
- MAX_WORDS, 512: maximum words per packet, including the sop and eop words.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- ff_tx_data  in  32  packet word; byte 0 is bits 31:24
- ff_tx_sop  in  1  first word of packet
- ff_tx_eop  in  1  last word of packet
- ff_tx_err  in  1  producer error flag, sampled on the eop word
- ff_tx_mod  in  2  count of invalid trailing bytes in the eop word
- ff_tx_wren  in  1  word valid
- ff_tx_rdy  out  1  sink can accept words
- out_data  out  8  serialized byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the byte
- out_first  out  1  first byte of packet
- out_last  out  1  last byte of packet
- out_err  out  1  packet error; valid with out_last
- overflow  out  1  sticky: a write was attempted while the FIFO was full
- framing_err  out  1  sticky: a sop/eop protocol violation occurred
- pkt_count  out  16  completed packets (optional feature)
- err_count  out  16  error packets (optional feature)

Behaviour:
- Reset:
  - All outputs reset to 0, including ff_tx_rdy; the FIFO is emptied and the FSM returns to IDLE.
  - Asserting reset mid-packet discards all buffered data and the partial byte.
- Write acceptance:
  - A word is accepted at the rising edge where ff_tx_wren=1 and the FIFO is not full.
  - If ff_tx_wren=1 while the FIFO is full, the word is dropped and overflow is set.
- ff_tx_rdy:
  - Registered; high when free slots after this edge are 2 or more.
  - Producers may issue one more word after rdy falls.
- FIFO entry contents: {data, sop, eop, mod, err}.
- Framing FSM, evaluated on accepted words only:
  - IDLE:
    - sop=1 and eop=0: write the word, set word count to 1, go to IN_PKT.
    - sop=1 and eop=1: write a single-word packet, stay in IDLE.
    - sop=0: discard the word, set framing_err.
  - IN_PKT:
    - A plain word is written and the count increments.
    - eop=1: write the word, go to IDLE.
    - sop=1: set framing_err, write the word as the start of a new packet, restart the count. Downstream sees out_first with no preceding out_last.
    - If the count reaches MAX_WORDS-1 and the word is not eop: write it, go to TRUNC.
  - TRUNC:
    - Discard words until eop.
    - The eop word is written with err forced to 1; go to IDLE.
- Serializer:
  - Pops one entry, then emits bytes 31:24, 23:16, 15:8, 7:0.
  - Each byte is presented while out_valid=1 and advances on out_valid and out_ready both high.
  - For the eop entry, the byte count is 4-mod; the last byte carries out_last=1 and out_err=entry err.
  - out_first=1 on byte 0 of a sop entry.
  - Latency: a word accepted at edge N is presented as out_valid at the cycle after edge N+1.
  - Throughput: one byte per cycle, with no bubble between entries when the FIFO is non-empty.
- out_* outputs are held stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop on a full FIFO: the push is accepted only if the FIFO was not full before the edge; no bypass path.
- Pointers are log2(FIFO_DEPTH)+1 bits wide with wrap bit; full/empty are computed from the pointer compare.

Optional Feature:
- MAC_TX_SINK_STATS_EN defined:
  - pkt_count increments on the last byte of each packet.
  - err_count increments when out_err=1 on that byte.
  - Both counters saturate at 0xFFFF and reset to 0.
- Not defined: pkt_count and err_count are tied to 0 and no counter logic is built.

Decomposition:
- Package mac_if_pkg holds:
  - MOD_W=2 and BYTES_PER_WORD=4
  - the FSM state enum {IDLE, IN_PKT, TRUNC}
  - the FIFO entry struct {data, sop, eop, mod, err}
- Sub-module mac_word_fifo: synchronous FIFO of packed entries exposing full, empty and the free count.
- The framing FSM and serializer stay in mac_tx_sink.

Test Plan:
- Full-length packet:
  - Stimulus: sop, 50 middle words, eop, mod=0; data is a counting byte pattern starting at 0x00010203; out_ready=1.
  - Response: bytes 0x00..0xCF in order, 208 bytes; out_first on 0x00; out_last on 0xCF; out_err=0; pkt_count=1.
- Short packet:
  - Stimulus: a single word 0xAABBCCDD with sop=eop=1 and mod=3.
  - Response: one byte 0xAA with out_first=out_last=1.
- Backpressure:
  - Stimulus: out_ready=0 while streaming 20 words into a FIFO_DEPTH=16 sink.
  - Response: ff_tx_rdy falls when free<2; the writes to 16 entries succeed; continued wren sets overflow=1.
- Framing errors:
  - Stimulus 1: a word without sop in IDLE. Response: no output bytes; framing_err=1.
  - Stimulus 2: a second sop mid-packet. Response: out_first asserted without a prior out_last.
- Truncation:
  - Stimulus: MAX_WORDS=8, a 12-word packet.
  - Response: 7 words and the eop word are output (32 bytes), out_err=1 on the last byte, err_count=1.
- Reset mid-packet:
  - Stimulus: assert reset_n=0 after 3 words, then release and send a clean 2-word packet.
  - Response: only the 8 bytes of the second packet are output; overflow=0 and framing_err=0.
